// File: rtl/dual_fetch_queue_if.sv
// dual_fetch_queue_if: instruction-memory request/response bus between the fetch queue and imem
// master (fetch queue): drives imem_req/imem_addr, samples imem_gnt/imem_rvalid/imem_rdata
// slave  (memory):      samples imem_req/imem_addr, drives imem_gnt/imem_rvalid/imem_rdata
interface dual_fetch_queue_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/dual_fetch_queue.sv
// dual_fetch_queue: pairwise instruction fetch into a circular queue feeding the relayer two instructions per cycle
// clk/rst         : clock, asynchronous active-high reset
// imem            : pair request (addr, addr+1) and one-cycle-latency 32-bit response
// isstall         : relayer consumes nothing; issingleinstr: relayer consumes one
// redirect_valid/redirect_pc : flush queue and restart fetch at redirect_pc
// instr1_o/instr2_o : two oldest entries, 16'h0 where the queue has none
// count_o/empty_o : current occupancy
module dual_fetch_queue #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    dual_fetch_queue_if.master       imem,
    input  logic                     isstall,
    input  logic                     issingleinstr,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [15:0]              instr1_o,
    output logic [15:0]              instr2_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt, wr_nxt;
    logic [CNT_W-1:0]  count_q, count_d, avail, take;
    logic              inflight_q, inflight_d, drop_q, drop_d;
    logic [15:0]       mem_q [DEPTH];
    logic [15:0]       mem_d [DEPTH];
    logic              issue, accept;
    // A pair is only requested when the queue can absorb it regardless of dequeue.
    assign imem.imem_req  = !rst && !redirect_valid && !inflight_q && (count_q <= CNT_W'(DEPTH - 2));
    assign imem.imem_addr = pc_q;
    assign issue    = imem.imem_req && imem.imem_gnt;
    assign accept   = imem.imem_rvalid && inflight_q && !drop_q;
    assign rd_nxt   = rd_ptr_q + PTR_W'(1);
    assign wr_nxt   = wr_ptr_q + PTR_W'(1);
    assign avail    = (count_q >= TWO) ? TWO : count_q;
    assign take     = isstall ? '0 : issingleinstr ? ((avail != '0) ? ONE : '0) : avail;
    assign instr1_o = (count_q != '0) ? mem_q[rd_ptr_q] : 16'h0;
    assign instr2_o = (count_q >= TWO) ? mem_q[rd_nxt] : 16'h0;
    assign count_o  = count_q;
    assign empty_o  = (count_q == '0);
    always_comb begin
        mem_d      = mem_q;
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // A response landing in the redirect cycle is simply discarded; only a
            // response still to come needs to be marked for dropping.
            inflight_d = inflight_q && !imem.imem_rvalid;
            drop_d     = inflight_q && !imem.imem_rvalid;
        end else begin
            if (accept) begin
                mem_d[wr_ptr_q] = imem.imem_rdata[15:0];
                mem_d[wr_nxt]   = imem.imem_rdata[31:16];
                wr_ptr_d        = wr_ptr_q + PTR_W'(2);
            end
            rd_ptr_d = rd_ptr_q + take[PTR_W-1:0];
            count_d  = count_q - take + (accept ? TWO : '0);
            if (imem.imem_rvalid && inflight_q) begin
                inflight_d = 1'b0;
                drop_d     = 1'b0;
            end
            if (issue) begin
                pc_d       = pc_q + ADDR_W'(2);
                inflight_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= ADDR_W'(RESET_PC);
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            mem_q      <= mem_d;
        end
    end
endmodule

// File: tb/tb_dual_fetch_queue.sv
// tb_dual_fetch_queue: randomized and directed checks of dual_fetch_queue against a queue-based model
module tb_dual_fetch_queue;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    logic        clk = 1'b0;
    logic        rst, isstall, single, redir;
    logic [15:0] rpc, instr1, instr2;
    logic [CW-1:0] count;
    logic        empty;
    int          errs = 0, checks = 0;
    logic [15:0] mq[$];
    logic [15:0] m_pc;
    bit          m_inflight, m_drop, spur_en;
    dual_fetch_queue_if #(.ADDR_W(16)) bus ();
    dual_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(16), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .imem(bus.master), .isstall(isstall), .issingleinstr(single),
        .redirect_valid(redir), .redirect_pc(rpc), .instr1_o(instr1), .instr2_o(instr2),
        .count_o(count), .empty_o(empty));
    always #5 clk = ~clk;
    function automatic logic [15:0] word(input logic [15:0] a);
        return 16'h1234 + 16'h1111 * a;
    endfunction
    task automatic step();
        logic [15:0] e1, e2, iaddr;
        logic [CW-1:0] ec;
        bit ereq, iss, mem_iss;
        int avail, k;
        #1;
        e1 = mq.size() > 0 ? mq[0] : 16'h0;
        e2 = mq.size() > 1 ? mq[1] : 16'h0;
        ec = CW'(mq.size());
        ereq = !redir && !m_inflight && (DEPTH - mq.size() >= 2);
        checks += 5;
        if (instr1 !== e1) begin errs++; $display("FAIL instr1: got %h expected %h", instr1, e1); end
        if (instr2 !== e2) begin errs++; $display("FAIL instr2: got %h expected %h", instr2, e2); end
        if (count !== ec) begin errs++; $display("FAIL count: got %0d expected %0d", count, ec); end
        if (empty !== (ec == 0)) begin errs++; $display("FAIL empty: got %b expected %b", empty, ec == 0); end
        if (bus.imem_req !== ereq) begin errs++; $display("FAIL req: got %b expected %b", bus.imem_req, ereq); end
        if (ereq) begin
            checks++;
            if (bus.imem_addr !== m_pc) begin errs++; $display("FAIL addr: got %h expected %h", bus.imem_addr, m_pc); end
        end
        iss = ereq && bus.imem_gnt;
        if (redir) begin
            mq.delete();
            m_pc = rpc;
            m_inflight = m_inflight && !bus.imem_rvalid;
            m_drop = m_inflight;
        end else begin
            avail = mq.size() < 2 ? mq.size() : 2;
            k = isstall ? 0 : single ? (avail > 0 ? 1 : 0) : avail;
            repeat (k) void'(mq.pop_front());
            if (bus.imem_rvalid && m_inflight) begin
                if (!m_drop) begin
                    mq.push_back(bus.imem_rdata[15:0]);
                    mq.push_back(bus.imem_rdata[31:16]);
                end
                m_drop = 0;
                m_inflight = 0;
            end
            if (iss) begin
                m_pc += 16'd2;
                m_inflight = 1;
            end
        end
        mem_iss = bus.imem_req && bus.imem_gnt;
        iaddr = bus.imem_addr;
        @(posedge clk);
        #1;
        bus.imem_rvalid = mem_iss || (spur_en && $urandom_range(0, 3) == 0);
        bus.imem_rdata = mem_iss ? {word(iaddr + 16'd1), word(iaddr)} : $urandom;
    endtask
    task automatic model_clear();
        mq.delete();
        m_pc = 16'h0;
        m_inflight = 0;
        m_drop = 0;
    endtask
    task automatic check_reset_outputs(input string tag);
        checks += 6;
        if (instr1 !== 16'h0) begin errs++; $display("FAIL %s_instr1: got %h expected 0000", tag, instr1); end
        if (instr2 !== 16'h0) begin errs++; $display("FAIL %s_instr2: got %h expected 0000", tag, instr2); end
        if (count !== '0) begin errs++; $display("FAIL %s_count: got %0d expected 0", tag, count); end
        if (empty !== 1'b1) begin errs++; $display("FAIL %s_empty: got %b expected 1", tag, empty); end
        if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL %s_req: got %b expected 0", tag, bus.imem_req); end
        if (bus.imem_addr !== 16'h0) begin errs++; $display("FAIL %s_pc: got %h expected 0000", tag, bus.imem_addr); end
    endtask
    task automatic test_reset();
        rst = 1; isstall = 0; single = 0; redir = 0; rpc = 0;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
    endtask
    task automatic test_basic();
        bus.imem_gnt = 1; isstall = 0; single = 0;
        step();
        step();
        #1;
        checks += 4;
        if (instr1 !== 16'h1234) begin errs++; $display("FAIL basic_instr1: got %h expected 1234", instr1); end
        if (instr2 !== 16'h2345) begin errs++; $display("FAIL basic_instr2: got %h expected 2345", instr2); end
        if (bus.imem_req !== 1'b1) begin errs++; $display("FAIL basic_req: got %b expected 1", bus.imem_req); end
        if (bus.imem_addr !== 16'h2) begin errs++; $display("FAIL basic_addr: got %h expected 0002", bus.imem_addr); end
        repeat (20) step();
    endtask
    task automatic test_fill_stall();
        bus.imem_gnt = 1; isstall = 1; single = 0;
        repeat (12) step();
        #1;
        checks += 2;
        if (count !== CW'(DEPTH)) begin errs++; $display("FAIL fill_count: got %0d expected %0d", count, DEPTH); end
        if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL fill_req: got %b expected 0", bus.imem_req); end
        repeat (3) step();
        bus.imem_gnt = 0; isstall = 0;
        repeat (5) step();
        #1;
        checks++;
        if (count !== '0) begin errs++; $display("FAIL drain_count: got %0d expected 0", count); end
    endtask
    task automatic test_single();
        logic [15:0] b, c;
        bus.imem_gnt = 1; isstall = 1; single = 0;
        for (int i = 0; i < 10 && mq.size() < 4; i++) step();
        while (m_inflight) step();
        bus.imem_gnt = 0; isstall = 0; single = 1;
        b = mq.size() > 1 ? mq[1] : 16'hxxxx;
        c = mq.size() > 2 ? mq[2] : 16'hxxxx;
        step();
        #1;
        checks += 3;
        if (instr1 !== b) begin errs++; $display("FAIL single_instr1: got %h expected %h", instr1, b); end
        if (instr2 !== c) begin errs++; $display("FAIL single_instr2: got %h expected %h", instr2, c); end
        if (count !== CW'(3)) begin errs++; $display("FAIL single_count: got %0d expected 3", count); end
    endtask
    task automatic test_single_entry();
        logic [15:0] x;
        bus.imem_gnt = 0; isstall = 0; single = 1;
        for (int i = 0; i < 8 && mq.size() > 1; i++) step();
        x = mq.size() > 0 ? mq[0] : 16'hxxxx;
        #1;
        checks += 2;
        if (instr1 !== x) begin errs++; $display("FAIL one_instr1: got %h expected %h", instr1, x); end
        if (instr2 !== 16'h0) begin errs++; $display("FAIL one_instr2: got %h expected 0000", instr2); end
        single = 0;
        step();
        #1;
        checks += 2;
        if (count !== '0) begin errs++; $display("FAIL one_count: got %0d expected 0", count); end
        if (empty !== 1'b1) begin errs++; $display("FAIL one_empty: got %b expected 1", empty); end
    endtask
    task automatic test_redirect();
        bus.imem_gnt = 1; isstall = 1; single = 0;
        step();
        for (int i = 0; i < 6 && !m_inflight; i++) step();
        redir = 1; rpc = 16'h0040;
        step();
        redir = 0;
        #1;
        checks += 3;
        if (count !== '0) begin errs++; $display("FAIL redir_count: got %0d expected 0", count); end
        if (bus.imem_req !== 1'b1) begin errs++; $display("FAIL redir_req: got %b expected 1", bus.imem_req); end
        if (bus.imem_addr !== 16'h0040) begin errs++; $display("FAIL redir_addr: got %h expected 0040", bus.imem_addr); end
        step();
        step();
        #1;
        checks += 2;
        if (instr1 !== 16'h5674) begin errs++; $display("FAIL redir_instr1: got %h expected 5674", instr1); end
        if (instr2 !== 16'h6785) begin errs++; $display("FAIL redir_instr2: got %h expected 6785", instr2); end
        isstall = 0;
        repeat (6) step();
    endtask
    task automatic test_reset_mid();
        bus.imem_gnt = 1; isstall = 1; single = 0;
        step();
        for (int i = 0; i < 6 && !m_inflight; i++) step();
        rst = 1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
        isstall = 0;
        bus.imem_rvalid = 1;
        bus.imem_rdata = 32'hDEADBEEF;
        step();
        #1;
        checks++;
        if (count !== '0) begin errs++; $display("FAIL late_count: got %0d expected 0", count); end
        step();
        #1;
        checks++;
        if (instr1 !== 16'h1234) begin errs++; $display("FAIL restart_instr1: got %h expected 1234", instr1); end
    endtask
    task automatic test_random();
        spur_en = 1;
        for (int i = 0; i < 400; i++) begin
            isstall = ($urandom_range(0, 2) == 0);
            single = ($urandom_range(0, 2) == 0);
            bus.imem_gnt = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 19) == 0);
            rpc = 16'($urandom);
            step();
        end
        redir = 0;
        spur_en = 0;
    endtask
    initial begin
        spur_en = 0;
        test_reset();
        test_basic();
        test_fill_stall();
        test_single();
        test_single_entry();
        test_redirect();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
